// File: rtl/bank_arbiter.sv
// -----------------------------------------------------------------------------
// bank_arbiter
//
// Round-robin arbiter and sequencer in front of a single bank memory. One
// request at a time is granted, driven onto the bank strobes, and completed
// when the bank raises finish (or aborted with an error after TIMEOUT+1 issue
// cycles without finish). The owning requester then gets a one-cycle rsp_valid
// pulse with the read data and error flag.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   req_valid/req_write : per-requester request and direction (1 = write)
//   req_addr/req_wdata  : packed per-requester address and write data
//   req_ready           : one-hot accept pulse (combinational, IDLE only)
//   rsp_valid           : one-hot completion pulse for the owning requester
//   rsp_data/rsp_err    : shared read data and timeout flag, held until the
//                         next completion
//   bank_read/bank_write: registered bank strobes, never both high
//   bank_addr/bank_wdata: latched address and write data for the bank
//   bank_rdata          : bank read data, meaningful while bank_read is high
//   bank_finish         : bank completion indication
// -----------------------------------------------------------------------------
module bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      bank_read,
    output logic                      bank_write,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [DATA_W-1:0]         bank_wdata,
    input  logic [DATA_W-1:0]         bank_rdata,
    input  logic                      bank_finish
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     own_q, own_d;
    logic                 wr_q, wr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_stb_q, rd_stb_d;
    logic                 wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;

    // Round-robin search starting just after the last granted requester.
    // cand carries one extra bit so last+i can exceed NUM_REQ-1 before wrap.
    always_comb begin : p_grant
        logic [IDX_W:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Accept pulse is masked by reset so nothing looks accepted while the
    // state registers are being held clear.
    always_comb begin
        req_ready = '0;
        if (reset && (state_q == ST_IDLE) && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        own_d       = own_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        rd_stb_d    = rd_stb_q;
        wr_stb_d    = wr_stb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    own_d    = grant_idx;
                    last_d   = grant_idx;
                    wr_d     = req_write[grant_idx];
                    addr_d   = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    wdata_d  = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                    cnt_d    = '0;
                    rd_stb_d = ~req_write[grant_idx];
                    wr_stb_d = req_write[grant_idx];
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bank_finish) begin
                    rsp_data_d         = wr_q ? '0 : bank_rdata;
                    rsp_err_d          = 1'b0;
                    rsp_valid_d[own_q] = 1'b1;
                    rd_stb_d           = 1'b0;
                    wr_stb_d           = 1'b0;
                    state_d            = ST_RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[own_q] = 1'b1;
                    rd_stb_d           = 1'b0;
                    wr_stb_d           = 1'b0;
                    state_d            = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Wait out a lingering finish so it cannot complete the next
                // transaction.
                if (!bank_finish) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_RST;
            own_q       <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            own_q       <= own_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bank_read  = rd_stb_q;
    assign bank_write = wr_stb_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bank_arbiter
//
// Bench for bank_arbiter with a simple bank model (finish registered one edge
// after a strobe, optional stuck-low finish and optional lingering finish).
// Each observed grant is checked against a round-robin reference and the
// expected completion (owner, data, error, cycle) is queued; a monitor pops
// and compares whenever rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_bank_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      bank_read;
    logic                      bank_write;
    logic [ADDR_W-1:0]         bank_addr;
    logic [DATA_W-1:0]         bank_wdata;
    logic [DATA_W-1:0]         bank_rdata;
    logic                      bank_finish;

    bank_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bank_read(bank_read), .bank_write(bank_write),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .bank_finish(bank_finish)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // ---------------- bank model ----------------
    bit [7:0] bmem [256];
    bit       bwr  [256];
    bit       bank_dead   = 1'b0;
    int       stale_extra = 0;
    int       hold;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank_finish <= 1'b0;
            hold        <= 0;
        end else begin
            if (bank_write) begin
                bmem[bank_addr] <= bank_wdata;
                bwr[bank_addr]  <= 1'b1;
            end
            if (bank_dead) begin
                bank_finish <= 1'b0;
                hold        <= 0;
            end else if (bank_read || bank_write) begin
                bank_finish <= 1'b1;
                hold        <= stale_extra;
            end else if (hold > 0) begin
                bank_finish <= 1'b1;
                hold        <= hold - 1;
            end else begin
                bank_finish <= 1'b0;
            end
        end
    end

    assign bank_rdata = bank_read ? (bwr[bank_addr] ? bmem[bank_addr] : init_val(bank_addr))
                                  : 8'hEE;

    // ---------------- reference model ----------------
    bit [7:0] mmem [256];
    bit       mwr  [256];
    int       mdl_last = NUM_REQ - 1;

    typedef struct {
        int       idx;
        logic [7:0] data;
        logic     err;
        int       cyc;
    } rsp_t;
    rsp_t exp_q[$];

    function automatic logic [7:0] mread(input logic [7:0] a);
        return mwr[a] ? mmem[a] : init_val(a);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [NUM_REQ-1:0] grant_seen;
    int   sc_cyc = -1;
    bit   sc_wr;
    logic [7:0] sc_addr, sc_wdata;
    int   last_gcyc = -1;
    bit   fair_mode = 1'b0;
    bit   fair_prev = 1'b0;
    int   m_g;
    rsp_t m_e;

    initial begin
        grant_seen = '0;
        forever begin
            @(negedge clock);
            grant_seen = req_ready;
            if (!reset) begin
                check("rst_ready", req_ready, 0);
                check("rst_strobes", {bank_read, bank_write}, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_bank_addr", bank_addr, 0);
                check("rst_bank_wdata", bank_wdata, 0);
                check("rst_rsp_data", rsp_data, 0);
                check("rst_rsp_err", rsp_err, 0);
                exp_q.delete();
                mdl_last  = NUM_REQ - 1;
                sc_cyc    = -1;
                fair_prev = 1'b0;
            end else begin
                check("strobe_exclusive", {31'b0, bank_read & bank_write}, 0);
                if (sc_cyc == cyc) begin
                    check("issue_read", bank_read, !sc_wr);
                    check("issue_write", bank_write, sc_wr);
                    check("issue_addr", bank_addr, sc_addr);
                    if (sc_wr) check("issue_wdata", bank_wdata, sc_wdata);
                    sc_cyc = -1;
                end
                if (req_ready != 0) begin
                    m_g = rr_pick(req_valid, mdl_last);
                    check("grant", req_ready, (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
                    check("ready_without_finish", bank_finish, 0);
                    if (fair_mode) begin
                        if (fair_prev) check("fair_interval", cyc - last_gcyc, 5);
                        fair_prev = 1'b1;
                    end else begin
                        fair_prev = 1'b0;
                    end
                    last_gcyc = cyc;
                    if (m_g >= 0) begin
                        sc_wr    = req_write[m_g];
                        sc_addr  = req_addr[m_g*ADDR_W +: ADDR_W];
                        sc_wdata = req_wdata[m_g*DATA_W +: DATA_W];
                        sc_cyc   = cyc + 1;
                        m_e.idx  = m_g;
                        m_e.err  = bank_dead;
                        m_e.data = (bank_dead || sc_wr) ? 8'h00 : mread(sc_addr);
                        m_e.cyc  = cyc + (bank_dead ? TIMEOUT + 2 : 3);
                        exp_q.push_back(m_e);
                        if (sc_wr) begin
                            mmem[sc_addr] = sc_wdata;
                            mwr[sc_addr]  = 1'b1;
                        end
                        mdl_last = m_g;
                    end
                end
                if (rsp_valid != 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("rsp_owner", rsp_valid, 32'd1 << m_e.idx);
                        check("rsp_data", rsp_data, m_e.data);
                        check("rsp_err", rsp_err, m_e.err);
                        check("rsp_cycle", cyc, m_e.cyc);
                        check("rsp_strobes_low", {bank_read, bank_write}, 0);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    bit [NUM_REQ-1:0]   reissue   = '0;
    bit                 rand_mode = 1'b0;
    logic [NUM_REQ-1:0] step_grant;

    task automatic post(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        step_grant = grant_seen;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (step_grant[i] && !reissue[i]) req_valid[i] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(3) == 0)
                        post(i, 1'($urandom_range(1)), 8'h40 + 8'($urandom_range(7)), 8'($urandom));
                end else if (!step_grant[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_grant(input string name, input int limit, output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int k = 0; k < limit; k++) begin
            step();
            if (step_grant != 0) begin
                g = step_grant;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: no grant within %0d cycles", name, limit);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check(name, exp_q.size(), 0);
        repeat (3) step();
    endtask

    logic [NUM_REQ-1:0] g;
    int fexp;
    int c1;

    initial begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        // Pending request during reset must not be accepted.
        post(0, 1'b1, 8'h3C, 8'hA5);
        repeat (3) step();
        reset = 1'b1;

        // Single write then read.
        wait_grant("wr_grant", 10, g);
        check("wr_grant_req0", g, 4'b0001);
        wait_drain("wr_drain", 20);
        post(0, 1'b0, 8'h3C, 8'h00);
        wait_grant("rd_grant", 10, g);
        check("rd_grant_req0", g, 4'b0001);
        wait_drain("rd_drain", 20);
        check("rd_data_held", rsp_data, 8'hA5);

        // Round-robin fairness, continuous reads of 0x10..0x13.
        for (int i = 0; i < NUM_REQ; i++) post(i, 1'b0, 8'h10 + 8'(i), 8'h00);
        reissue   = '1;
        fair_mode = 1'b1;
        fexp      = 1;
        for (int n = 0; n < 12; n++) begin
            wait_grant("fair_grant", 10, g);
            check("fair_order", g, 32'd1 << fexp);
            fexp = (fexp + 1) % NUM_REQ;
        end
        reissue   = '0;
        fair_mode = 1'b0;
        req_valid = '0;
        wait_drain("fair_drain", 20);

        // Wrap-around: after req3, req1 wins over req3.
        post(3, 1'b0, 8'h20, 8'h00);
        wait_grant("wrap_first", 10, g);
        check("wrap_first_req3", g, 4'b1000);
        wait_drain("wrap_drain1", 20);
        post(1, 1'b0, 8'h21, 8'h00);
        post(3, 1'b0, 8'h22, 8'h00);
        wait_grant("wrap_second", 10, g);
        check("wrap_second_req1", g, 4'b0010);
        req_valid = '0;
        wait_drain("wrap_drain2", 20);

        // Timeout with finish stuck low, read then write.
        bank_dead = 1'b1;
        post(2, 1'b0, 8'h30, 8'h00);
        wait_grant("to_rd_grant", 10, g);
        wait_drain("to_rd_drain", 40);
        post(1, 1'b1, 8'h31, 8'h77);
        wait_grant("to_wr_grant", 10, g);
        wait_drain("to_wr_drain", 40);
        bank_dead = 1'b0;
        repeat (2) step();

        // Stale finish held 3 extra cycles delays the next grant by 3.
        stale_extra = 3;
        post(1, 1'b1, 8'h32, 8'h66);
        post(0, 1'b0, 8'h32, 8'h00);
        wait_grant("stale_first", 10, g);
        c1 = last_gcyc;
        wait_grant("stale_second", 20, g);
        stale_extra = 0;
        check("stale_gap", last_gcyc - c1, 8);
        wait_drain("stale_drain", 20);

        // Reset in the first ISSUE cycle of a read.
        post(1, 1'b0, 8'h33, 8'h00);
        wait_grant("mid_grant", 10, g);
        check("mid_grant_req1", g, 4'b0010);
        check("mid_read_before_reset", bank_read, 1);
        reset = 1'b0;
        #1;
        check("mid_read_dropped", bank_read, 0);
        repeat (3) step();
        reset = 1'b1;
        post(0, 1'b0, 8'h34, 8'h00);
        post(3, 1'b0, 8'h35, 8'h00);
        wait_grant("post_reset_grant", 10, g);
        check("post_reset_req0", g, 4'b0001);
        wait_grant("post_reset_second", 10, g);
        check("post_reset_req3", g, 4'b1000);
        wait_drain("post_reset_drain", 20);

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        req_valid = '0;
        wait_drain("rand_drain", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
